sort_pkt_framer: RTL and testbench

Input conditioning stage placed directly upstream of the sort engine on the packet stream interface (data/sop/eop/val/ready). Repairs framing and enforces the engine's capacity limit by splitting any packet longer than 2**AWIDTH words into consecutive legal packets. Drops words that arrive outside a packet. Output is registered behind a two-entry skid buffer, so both `ready_o` and `val_o` come from flops and the engine input needs no extra retiming.

---
 rtl/sort_pkt_framer.sv | 153 +++++++++++++++
 tb/tb_sort_pkt_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sort_pkt_framer.sv
// rtl/sort_pkt_framer.sv - packet framing repair and MAXLEN splitting ahead of the sort engine
module sort_pkt_framer #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic              ready_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    input  logic              ready_i,
    output logic              err_orphan_o,
    output logic              err_nested_o,
    output logic              split_o,
    output logic [31:0]       pkt_cnt_o
);

    typedef enum logic [1:0] {IDLE, IN_PKT, SPLIT} state_t;

    localparam logic [AWIDTH:0] MAXLEN = (AWIDTH + 1)'(1) << AWIDTH;
    localparam logic [AWIDTH:0] ONE    = (AWIDTH + 1)'(1);

    state_t            state, state_nxt;
    logic [AWIDTH:0]   cnt, cnt_nxt;

    logic              emit, emit_sop, emit_eop;
    logic              orphan, nested, split;

    logic              out_val, out_sop, out_eop;
    logic [DWIDTH-1:0] out_data;
    logic              skid_val, skid_sop, skid_eop;
    logic [DWIDTH-1:0] skid_data;
    logic              skid_val_nxt;
    logic              ready_r;

    logic              accept, drain;

    // ready_r resets to 1 so the framer is ready the first cycle reset is released.
    assign ready_o = ready_r & ~rst_i;
    assign accept  = val_i & ready_o;
    assign drain   = out_val & ready_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        emit_sop  = 1'b0;
        emit_eop  = 1'b0;
        orphan    = 1'b0;
        nested    = 1'b0;
        split     = 1'b0;
        if (accept) begin
            if (state == IDLE) begin
                if (!sop_i) begin
                    orphan = 1'b1;
                end else begin
                    emit     = 1'b1;
                    emit_sop = 1'b1;
                    cnt_nxt  = ONE;
                end
            end else begin
                emit = 1'b1;
                if (state == SPLIT) begin
                    emit_sop = 1'b1;
                    cnt_nxt  = ONE;
                end else begin
                    cnt_nxt = cnt + ONE;
                    nested  = sop_i;
                end
            end
            if (emit) begin
                if (eop_i) begin
                    emit_eop  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_nxt == MAXLEN) begin
                    emit_eop  = 1'b1;
                    split     = 1'b1;
                    state_nxt = SPLIT;
                end else begin
                    state_nxt = IN_PKT;
                end
            end
        end
    end

    // The skid register only fills when the output register holds a word that is not leaving.
    assign skid_val_nxt = (emit && out_val && !drain) || (skid_val && !drain);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            out_val      <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_data     <= '0;
            skid_val     <= 1'b0;
            skid_sop     <= 1'b0;
            skid_eop     <= 1'b0;
            skid_data    <= '0;
            ready_r      <= 1'b1;
            err_orphan_o <= 1'b0;
            err_nested_o <= 1'b0;
            split_o      <= 1'b0;
            pkt_cnt_o    <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            err_orphan_o <= orphan;
            err_nested_o <= nested;
            split_o      <= split;
            ready_r      <= ~skid_val_nxt;

            if (drain && out_eop) begin
                pkt_cnt_o <= pkt_cnt_o + 32'd1;
            end

            if (emit && (!out_val || drain)) begin
                out_val  <= 1'b1;
                out_data <= data_i;
                out_sop  <= emit_sop;
                out_eop  <= emit_eop;
            end else if (drain) begin
                if (skid_val) begin
                    out_data <= skid_data;
                    out_sop  <= skid_sop;
                    out_eop  <= skid_eop;
                end else begin
                    out_val <= 1'b0;
                end
            end

            if (emit && out_val && !drain) begin
                skid_data <= data_i;
                skid_sop  <= emit_sop;
                skid_eop  <= emit_eop;
            end
            skid_val <= skid_val_nxt;
        end
    end

    assign val_o  = out_val;
    assign data_o = out_data;
    assign sop_o  = out_sop;
    assign eop_o  = out_eop;

endmodule

// File: tb/tb_sort_pkt_framer.sv
// tb/tb_sort_pkt_framer.sv - directed bench for sort_pkt_framer with AWIDTH=2 (MAXLEN=4)
module tb_sort_pkt_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = '0;
    logic        sop_i = 1'b0, eop_i = 1'b0, val_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        sop_o, eop_o, val_o;
    logic        ready_i = 1'b1;
    logic        err_orphan_o, err_nested_o, split_o;
    logic [31:0] pkt_cnt_o;

    int total = 0;
    int bad   = 0;

    sort_pkt_framer #(.AWIDTH(2), .DWIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
        .val_i(val_i), .ready_o(ready_o), .data_o(data_o), .sop_o(sop_o),
        .eop_o(eop_o), .val_o(val_o), .ready_i(ready_i),
        .err_orphan_o(err_orphan_o), .err_nested_o(err_nested_o),
        .split_o(split_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk = ~clk;

    // Observed transfers and event counts, sampled on the falling edge.
    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];
    int          tcyc_q[$];
    int          cyc = 0;
    int          n_orphan = 0, n_nested = 0, n_split = 0;
    int          unstable = 0, stall_acc = 0, saw_low = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (val_o && ready_i) begin
            got_q.push_back({data_o, sop_o, eop_o});
            tcyc_q.push_back(cyc);
        end
        if (err_orphan_o) n_orphan++;
        if (err_nested_o) n_nested++;
        if (split_o) n_split++;
        if (prev_stall && val_o && ({data_o, sop_o, eop_o} != prev_word)) unstable++;
        if (!ready_i && val_i && ready_o) stall_acc++;
        if (!ready_i && !ready_o) saw_low = 1;
        prev_stall = val_o && !ready_i;
        prev_word  = {data_o, sop_o, eop_o};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        tcyc_q.delete();
        n_orphan = 0; n_nested = 0; n_split = 0;
        unstable = 0; stall_acc = 0; saw_low = 0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic s, input logic e);
        exp_q.push_back({d, s, e});
    endtask

    task automatic send_word(input logic [31:0] d, input logic s, input logic e);
        int n = 0;
        data_i = d; sop_i = s; eop_i = e; val_i = 1'b1;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        val_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string name);
        chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", 64'(val_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(ready_o), 64'd1);
        clear_mon();

        // Normal 3-word packet with 1-cycle latency
        send_word(32'hA0, 1'b1, 1'b0);
        chk("lat_val", 64'(val_o), 64'd1);
        chk("lat_data", 64'(data_o), 64'hA0);
        send_word(32'hA1, 1'b0, 1'b0);
        send_word(32'hA2, 1'b0, 1'b1);
        idle(4);
        push_exp(32'hA0, 1, 0); push_exp(32'hA1, 0, 0); push_exp(32'hA2, 0, 1);
        compare_out("normal");
        chk("normal_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
        chk("normal_pulses", 64'(n_orphan + n_nested + n_split), 64'd0);
        clear_mon();

        // 10-word packet split into 4+4+2
        for (int i = 0; i < 10; i++)
            send_word(32'hD0 + i, i == 0, i == 9);
        idle(4);
        for (int i = 0; i < 10; i++)
            push_exp(32'hD0 + i, (i % 4) == 0, (i == 3) || (i == 7) || (i == 9));
        compare_out("split");
        chk("split_pulses", 64'(n_split), 64'd2);
        chk("split_pkt_cnt", 64'(pkt_cnt_o), 64'd4);
        if (tcyc_q.size() == 10)
            chk("split_no_bubble", 64'(tcyc_q[9] - tcyc_q[0]), 64'd9);
        else
            chk("split_no_bubble_cnt", 64'(tcyc_q.size()), 64'd10);
        clear_mon();

        // Exact MAXLEN packet ends normally
        for (int i = 0; i < 4; i++)
            send_word(32'hE0 + i, i == 0, i == 3);
        idle(4);
        for (int i = 0; i < 4; i++)
            push_exp(32'hE0 + i, i == 0, i == 3);
        compare_out("exact");
        chk("exact_split", 64'(n_split), 64'd0);
        chk("exact_pkt_cnt", 64'(pkt_cnt_o), 64'd5);
        clear_mon();

        // Orphan word in IDLE
        send_word(32'h55, 1'b0, 1'b0);
        idle(4);
        chk("orphan_out", 64'(got_q.size()), 64'd0);
        chk("orphan_pulse", 64'(n_orphan), 64'd1);
        clear_mon();

        // Nested sop on second word
        send_word(32'h61, 1'b1, 1'b0);
        send_word(32'h62, 1'b1, 1'b0);
        send_word(32'h63, 1'b0, 1'b1);
        idle(4);
        push_exp(32'h61, 1, 0); push_exp(32'h62, 0, 0); push_exp(32'h63, 0, 1);
        compare_out("nested");
        chk("nested_pulse", 64'(n_nested), 64'd1);
        chk("nested_pkt_cnt", 64'(pkt_cnt_o), 64'd6);
        clear_mon();

        // Backpressure: ready_i low for 5 cycles mid-packet
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_word(32'hB0 + i, i == 0, i == 5);
                idle(8);
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (5) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        for (int i = 0; i < 6; i++)
            push_exp(32'hB0 + i, (i == 0) || (i == 4), (i == 3) || (i == 5));
        compare_out("bp");
        chk("bp_ready_low", 64'(saw_low), 64'd1);
        chk("bp_held_le2", 64'(stall_acc <= 2), 64'd1);
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_pkt_cnt", 64'(pkt_cnt_o), 64'd8);
        clear_mon();

        // Reset mid-packet
        send_word(32'hC0, 1'b1, 1'b0);
        send_word(32'hC1, 1'b0, 1'b0);
        val_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_val", 64'(val_o), 64'd0);
        chk("mid_rst_sop_eop", 64'({sop_o, eop_o}), 64'd0);
        chk("mid_rst_data", 64'(data_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        chk("mid_rst_pulses", 64'({err_orphan_o, err_nested_o, split_o}), 64'd0);
        rst = 1'b0;
        #1;
        clear_mon();
        send_word(32'hC2, 1'b0, 1'b0);
        send_word(32'hC3, 1'b0, 1'b1);
        idle(3);
        chk("post_rst_orphans", 64'(n_orphan), 64'd2);
        chk("post_rst_no_out", 64'(got_q.size()), 64'd0);
        clear_mon();
        send_word(32'hF0, 1'b1, 1'b0);
        send_word(32'hF1, 1'b0, 1'b1);
        idle(4);
        push_exp(32'hF0, 1, 0); push_exp(32'hF1, 0, 1);
        compare_out("fresh");
        chk("fresh_pkt_cnt", 64'(pkt_cnt_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
